// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: operand-forwarding selectors and load-wait stall for an
// ID -> MEX -> WB pipeline. Selectors are registered alongside the ID/MEX
// pipe register, so they describe the instruction currently sitting in MEX.
// A load holds MEX for MEM_LAT cycles; the extra cycles are covered by stall.
// MEM_LAT legal range is 1..16 (the load counter is 4 bits wide).
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 3,
  parameter int MEM_LAT    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_use_imm,
  input  logic                  id_is_load,
  output logic [1:0]            fwd_unit_selector1,
  output logic [1:0]            fwd_unit_selector2,
  output logic                  stall
);

  // Operand mux codes
  localparam logic [1:0] SEL_REG = 2'd0;
  localparam logic [1:0] SEL_FWD = 2'd1;
  localparam logic [1:0] SEL_IMM = 2'd2;

  // Extra MEX cycles a load needs beyond the first one
  localparam logic [3:0] LD_INIT = 4'(MEM_LAT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Load-wait FSM state; r_state is WAIT exactly when r_ld_cnt is non-zero
  state_t r_state;
  state_t w_state_nxt;
  logic [3:0] r_ld_cnt;
  logic [3:0] w_ld_cnt_nxt;

  // In-flight destination tracking
  logic                  r_mex_valid;
  logic [REG_ADDR_W-1:0] r_mex_rd;
  logic                  r_mex_wr;
  logic                  r_wb_valid;
  logic [REG_ADDR_W-1:0] r_wb_rd;
  logic                  r_wb_wr;

  // Registered selectors
  logic [1:0] r_sel1;
  logic [1:0] r_sel2;

  // Combinational helpers
  logic       w_advance;
  logic       w_ld_capture;
  logic       w_mex_src;
  logic       w_hit1;
  logic       w_hit2;
  logic [1:0] w_sel1;
  logic [1:0] w_sel2;

  // The pipeline moves only when no load is waiting in MEX
  assign w_advance = (r_state == S_IDLE);

  // A single-cycle load never needs a wait, so it never arms the counter
  assign w_ld_capture = id_valid & id_is_load & (LD_INIT != 4'd0);

  // MEX holds a real instruction that writes a non-zero register
  assign w_mex_src = r_mex_valid & r_mex_wr & (r_mex_rd != '0);

  // Only distance-1 hazards need forwarding; WB is covered by the regfile
  assign w_hit1 = id_valid & w_mex_src & (id_rs1 == r_mex_rd);
  assign w_hit2 = id_valid & w_mex_src & (id_rs2 == r_mex_rd);

  // Selector decode; the immediate outranks a forward on operand 2
  always_comb begin
    w_sel1 = SEL_REG;
    w_sel2 = SEL_REG;
    if (w_hit1) w_sel1 = SEL_FWD;
    if (id_use_imm)  w_sel2 = SEL_IMM;
    else if (w_hit2) w_sel2 = SEL_FWD;
  end

  // Load-wait next state: arm on load capture, count down while waiting
  always_comb begin
    w_state_nxt  = r_state;
    w_ld_cnt_nxt = r_ld_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_ld_capture) begin
          w_state_nxt  = S_WAIT;
          w_ld_cnt_nxt = LD_INIT;
        end
      end
      S_WAIT: begin
        w_ld_cnt_nxt = r_ld_cnt - 4'd1;
        if (r_ld_cnt == 4'd1) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_ld_cnt_nxt = 4'd0;
      end
    endcase
  end

  // Load-wait state register; reset aborts a wait in progress
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ld_cnt <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_ld_cnt <= w_ld_cnt_nxt;
    end
  end

  // Tracking and selector registers advance together and freeze on stall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mex_valid <= 1'b0;
      r_mex_rd    <= '0;
      r_mex_wr    <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_wr     <= 1'b0;
      r_sel1      <= SEL_REG;
      r_sel2      <= SEL_REG;
    end else if (w_advance) begin
      r_wb_valid  <= r_mex_valid;
      r_wb_rd     <= r_mex_rd;
      r_wb_wr     <= r_mex_wr;
      r_mex_valid <= id_valid;
      r_mex_rd    <= id_rd;
      r_mex_wr    <= id_reg_write & id_valid;
      r_sel1      <= w_sel1;
      r_sel2      <= w_sel2;
    end
  end

  assign fwd_unit_selector1 = r_sel1;
  assign fwd_unit_selector2 = r_sel2;
  assign stall              = (r_state == S_WAIT);

  // WB tracking is a one-step-delayed copy of MEX tracking on every advance
  a_wb_follows_mex: assert property (
    @(posedge clk) disable iff (!rst_n)
    (rst_n && !stall) |=> (r_wb_valid == $past(r_mex_valid) &&
                           r_wb_rd    == $past(r_mex_rd) &&
                           r_wb_wr    == $past(r_mex_wr))
  );

  // Stall is exactly the non-zero load counter
  a_stall_cnt: assert property (
    @(posedge clk) disable iff (!rst_n) stall == (r_ld_cnt != 4'd0)
  );

endmodule
